lcd_write_seq: RTL and testbench

LCD write sequencer sitting directly downstream of the single-cycle core's LCD I/O register. The core posts 32-bit LCD command words; the block buffers them in a small FIFO and replays each one onto the HD44780-style character LCD pins with programmable setup, enable-pulse, hold and post-write busy-gap timing. This frees firmware from bit-banging EN and from software delay loops.

---
 rtl/lcd_write_seq_if.sv | 19 +
 rtl/lcd_write_seq.sv | 188 ++++++++++++++++++
 tb/tb_lcd_write_seq.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_write_seq_if.sv
// Core-side bus of the LCD write sequencer: command push, overflow clear and status.
interface lcd_write_seq_if;
    logic [31:0] i_lcd_wdata;
    logic        i_lcd_vld;
    logic        i_ovf_clr;
    logic        o_busy;
    logic        o_full;
    logic        o_ovf;

    modport master (
        output i_lcd_wdata, i_lcd_vld, i_ovf_clr,
        input  o_busy, o_full, o_ovf
    );

    modport slave (
        input  i_lcd_wdata, i_lcd_vld, i_ovf_clr,
        output o_busy, o_full, o_ovf
    );
endinterface

// File: rtl/lcd_write_seq.sv
// LCD write sequencer: buffers core command words in a small FIFO and replays
// each onto HD44780-style pins with setup / EN pulse / hold / busy-gap timing.
module lcd_write_seq #(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned EN_HIGH_CYC  = 12,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned GAP_CYC      = 2000,
    parameter int unsigned LONG_GAP_CYC = 82000,
    parameter int unsigned DEPTH        = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    lcd_write_seq_if.slave     bus,
    output logic               o_lcd_on,
    output logic               o_lcd_en,
    output logic               o_lcd_rs,
    output logic               o_lcd_rw,
    output logic [7:0]         o_lcd_data
);

    localparam int unsigned CW = $clog2(LONG_GAP_CYC + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_EN    = CW'(EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] LD_GAP   = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(LONG_GAP_CYC - 1);
    localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [9:0]      mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [NW-1:0]   count, count_next;
    logic [9:0]      head;
    logic            pop, push, drop, long_gap;
    logic            en_next, busy_next, full_next;
    logic            unused_wdata;

    // Bits 30:10 and the RW bit (8) of the command word carry nothing for this block.
    assign unused_wdata = ^{bus.i_lcd_wdata[30:10], bus.i_lcd_wdata[8]};

    assign head     = mem[rptr];
    assign pop      = (state == ST_IDLE) && (count != '0);
    // A full FIFO still accepts a push when the same edge pops an entry.
    assign push     = bus.i_lcd_vld && !i_rst && ((count != FULL_CNT) || pop);
    assign drop     = bus.i_lcd_vld && !i_rst && !push;
    // Clear display (0x01) and return home (0x02/0x03) need the long busy gap.
    assign long_gap = !o_lcd_rs && ((o_lcd_data[7:1] == 7'b0000000) ||
                                    (o_lcd_data == 8'h02) || (o_lcd_data == 8'h03));

    // FIFO occupancy after this edge.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + NW'(1);
        end else if (pop && !push) begin
            count_next = count - NW'(1);
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count_next;
        end
    end

    // FIFO storage of {ON, RS, DATA}.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wptr] <= {bus.i_lcd_wdata[31], bus.i_lcd_wdata[9], bus.i_lcd_wdata[7:0]};
        end
    end

    // FSM state and shared down-counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state and counter reload logic for the write phases.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (pop) begin
                    state_next = ST_SETUP;
                    cnt_next   = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_next = ST_PULSE;
                    cnt_next   = LD_EN;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    state_next = ST_HOLD;
                    cnt_next   = LD_HOLD;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_next = ST_GAP;
                    cnt_next   = long_gap ? LD_LONG : LD_GAP;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode from next-state values so registered outputs line up with the FSM.
    always_comb begin
        en_next   = (state_next == ST_PULSE);
        busy_next = (state_next != ST_IDLE) || (count_next != '0);
        full_next = (count_next == FULL_CNT);
    end

    // Registered pin and status outputs; RS/DATA/ON change only on a pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_lcd_on   <= 1'b0;
            o_lcd_en   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_rw   <= 1'b0;
            o_lcd_data <= '0;
            bus.o_busy <= 1'b0;
            bus.o_full <= 1'b0;
            bus.o_ovf  <= 1'b0;
        end else begin
            if (pop) begin
                o_lcd_on   <= head[9];
                o_lcd_rs   <= head[8];
                o_lcd_data <= head[7:0];
            end
            o_lcd_en   <= en_next;
            o_lcd_rw   <= 1'b0;
            bus.o_busy <= busy_next;
            bus.o_full <= full_next;
            if (drop) begin
                bus.o_ovf <= 1'b1;
            end else if (bus.i_ovf_clr) begin
                bus.o_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_write_seq.sv
// Self-checking bench for lcd_write_seq with short timing parameters.
module tb_lcd_write_seq;

    localparam int unsigned S  = 2;
    localparam int unsigned E  = 3;
    localparam int unsigned H  = 2;
    localparam int unsigned G  = 5;
    localparam int unsigned LG = 20;
    localparam int unsigned D  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_on, lcd_en, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    lcd_write_seq_if bus();

    lcd_write_seq #(
        .SETUP_CYC(S),
        .EN_HIGH_CYC(E),
        .HOLD_CYC(H),
        .GAP_CYC(G),
        .LONG_GAP_CYC(LG),
        .DEPTH(D)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus),
        .o_lcd_on(lcd_on),
        .o_lcd_en(lcd_en),
        .o_lcd_rs(lcd_rs),
        .o_lcd_rw(lcd_rw),
        .o_lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld;
        logic [31:0] wd;
        logic        en;
        logic        rs;
        logic [7:0]  data;
        logic        on;
        logic        busy;
    } vec_t;

    typedef struct packed {
        logic [31:0] wd;
        int          bfall;
        logic        rs;
        logic [7:0]  data;
    } cmd_t;

    int checks   = 0;
    int failures = 0;

    vec_t tbl [15];
    cmd_t cmds [6];

    function automatic vec_t mk(input logic vld, input logic [31:0] wd, input logic en,
                                input logic rs, input logic [7:0] data, input logic on,
                                input logic busy);
        vec_t v;
        v.vld = vld; v.wd = wd; v.en = en; v.rs = rs; v.data = data; v.on = on; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_lcd_vld   = 1'b0;
        bus.i_lcd_wdata = '0;
        bus.i_ovf_clr   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Push one word at edge 0 and record EN rise/fall and busy-fall edge numbers.
    task automatic measure(input logic [31:0] wd, output int rise, output int fall,
                           output int bfall, output logic rs1, output logic [7:0] d1);
        logic prev;
        rise = -1; fall = -1; bfall = -1; rs1 = 1'bx; d1 = 'x;
        prev = lcd_en;
        for (int t = 0; t < 45; t++) begin
            if (t == 0) begin
                bus.i_lcd_vld   = 1'b1;
                bus.i_lcd_wdata = wd;
            end
            tick();
            idle_inputs();
            if (lcd_en && !prev && rise < 0) rise = t;
            if (!lcd_en && prev && fall < 0) fall = t;
            if (!bus.o_busy && t > 0 && bfall < 0) bfall = t;
            if (t == 1) begin
                rs1 = lcd_rs;
                d1  = lcd_data;
            end
            prev = lcd_en;
        end
    endtask

    initial begin
        logic        prev_en;
        logic        bad_rw, bad_ovf;
        int          rise, fall, bfall;
        logic        rs1;
        logic [7:0]  d1;
        logic [7:0]  seen_d [$];
        int          seen_t [$];

        tbl[0]  = mk(1'b1, 32'h8000_0241, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        tbl[1]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 8'h41, 1'b1, 1'b1);
        tbl[2]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 8'h41, 1'b1, 1'b1);
        tbl[3]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 8'h41, 1'b1, 1'b1);
        tbl[4]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 8'h41, 1'b1, 1'b1);
        tbl[5]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 8'h41, 1'b1, 1'b1);
        tbl[6]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 8'h41, 1'b1, 1'b1);
        tbl[7]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 8'h41, 1'b1, 1'b1);
        tbl[8]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 8'h41, 1'b1, 1'b1);
        tbl[9]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 8'h41, 1'b1, 1'b1);
        tbl[10] = mk(1'b0, 32'h0,         1'b0, 1'b1, 8'h41, 1'b1, 1'b1);
        tbl[11] = mk(1'b0, 32'h0,         1'b0, 1'b1, 8'h41, 1'b1, 1'b1);
        tbl[12] = mk(1'b0, 32'h0,         1'b0, 1'b1, 8'h41, 1'b1, 1'b1);
        tbl[13] = mk(1'b0, 32'h0,         1'b0, 1'b1, 8'h41, 1'b1, 1'b0);
        tbl[14] = mk(1'b0, 32'h0,         1'b0, 1'b1, 8'h41, 1'b1, 1'b0);

        // Busy falls after edge 1+S+E+H+gap: 28 for long-gap commands, 13 otherwise.
        cmds[0] = '{wd: 32'h8000_0001, bfall: 28, rs: 1'b0, data: 8'h01};
        cmds[1] = '{wd: 32'h8000_0002, bfall: 28, rs: 1'b0, data: 8'h02};
        cmds[2] = '{wd: 32'h8000_0003, bfall: 28, rs: 1'b0, data: 8'h03};
        cmds[3] = '{wd: 32'h8000_0004, bfall: 13, rs: 1'b0, data: 8'h04};
        cmds[4] = '{wd: 32'h8000_0201, bfall: 13, rs: 1'b1, data: 8'h01};
        cmds[5] = '{wd: 32'h0000_0000, bfall: 28, rs: 1'b0, data: 8'h00};

        do_reset();
        chk("rst_on",   lcd_on,     0);
        chk("rst_en",   lcd_en,     0);
        chk("rst_rs",   lcd_rs,     0);
        chk("rst_rw",   lcd_rw,     0);
        chk("rst_data", lcd_data,   0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_full", bus.o_full, 0);
        chk("rst_ovf",  bus.o_ovf,  0);

        // Single data write, one row per edge.
        for (int i = 0; i < 15; i++) begin
            bus.i_lcd_vld   = tbl[i].vld;
            bus.i_lcd_wdata = tbl[i].wd;
            bus.i_ovf_clr   = 1'b0;
            tick();
            idle_inputs();
            chk($sformatf("vec%0d_en", i),   lcd_en,     tbl[i].en);
            chk($sformatf("vec%0d_rs", i),   lcd_rs,     tbl[i].rs);
            chk($sformatf("vec%0d_data", i), lcd_data,   tbl[i].data);
            chk($sformatf("vec%0d_on", i),   lcd_on,     tbl[i].on);
            chk($sformatf("vec%0d_busy", i), bus.o_busy, tbl[i].busy);
            chk($sformatf("vec%0d_full", i), bus.o_full, 0);
        end

        // Short versus long gap classification.
        for (int c = 0; c < 6; c++) begin
            measure(cmds[c].wd, rise, fall, bfall, rs1, d1);
            chk($sformatf("cmd%0d_rise", c),  rise,  3);
            chk($sformatf("cmd%0d_fall", c),  fall,  6);
            chk($sformatf("cmd%0d_bfall", c), bfall, cmds[c].bfall);
            chk($sformatf("cmd%0d_rs", c),    rs1,   cmds[c].rs);
            chk($sformatf("cmd%0d_data", c),  d1,    cmds[c].data);
        end

        // Burst of 6 pushes from idle: 5 accepted, 1 dropped.
        do_reset();
        prev_en = 1'b0;
        seen_d.delete();
        seen_t.delete();
        for (int t = 0; t < 80; t++) begin
            if (t < 6) begin
                bus.i_lcd_vld   = 1'b1;
                bus.i_lcd_wdata = 32'h8000_0210 + t;
            end
            tick();
            idle_inputs();
            if (t == 3) chk("burst_full_e3", bus.o_full, 0);
            if (t == 4) chk("burst_full_e4", bus.o_full, 1);
            if (t == 4) chk("burst_ovf_e4",  bus.o_ovf,  0);
            if (t == 5) chk("burst_ovf_e5",  bus.o_ovf,  1);
            if (lcd_en && !prev_en) begin
                seen_d.push_back(lcd_data);
                seen_t.push_back(t);
            end
            prev_en = lcd_en;
        end
        chk("burst_pulses", seen_d.size(), 5);
        for (int k = 0; k < seen_d.size() && k < 5; k++) begin
            chk($sformatf("burst_data%0d", k), seen_d[k], 8'h10 + k);
            chk($sformatf("burst_time%0d", k), seen_t[k], 3 + 13 * k);
        end
        chk("burst_idle", bus.o_busy, 0);
        chk("burst_ovf_sticky", bus.o_ovf, 1);

        // Reset mid-pulse with o_ovf set; a push during reset is ignored.
        bus.i_lcd_vld   = 1'b1;
        bus.i_lcd_wdata = 32'h8000_0241;
        for (int t = 0; t < 5; t++) begin
            tick();
            idle_inputs();
        end
        chk("rmid_en_before",  lcd_en,    1);
        chk("rmid_ovf_before", bus.o_ovf, 1);
        rst             = 1'b1;
        bus.i_lcd_vld   = 1'b1;
        bus.i_lcd_wdata = 32'h8000_0255;
        tick();
        rst = 1'b0;
        idle_inputs();
        chk("rmid_en",   lcd_en,     0);
        chk("rmid_on",   lcd_on,     0);
        chk("rmid_rs",   lcd_rs,     0);
        chk("rmid_data", lcd_data,   0);
        chk("rmid_busy", bus.o_busy, 0);
        chk("rmid_full", bus.o_full, 0);
        chk("rmid_ovf",  bus.o_ovf,  0);
        tick();
        chk("rmid_push_ignored", bus.o_busy, 0);
        measure(32'h8000_0241, rise, fall, bfall, rs1, d1);
        chk("rmid_rise",  rise,  3);
        chk("rmid_fall",  fall,  6);
        chk("rmid_bfall", bfall, 13);
        chk("rmid_data2", d1,    8'h41);

        // Push on full while the FSM pops; then a drop with i_ovf_clr in the same cycle.
        do_reset();
        prev_en = 1'b0;
        seen_d.delete();
        seen_t.delete();
        for (int t = 0; t < 91; t++) begin
            if (t == 0 || (t >= 2 && t <= 5) || t == 14 || t == 15) begin
                bus.i_lcd_vld   = 1'b1;
                bus.i_lcd_wdata = (t == 0) ? 32'h8000_0230 :
                                  (t == 14) ? 32'h8000_0235 :
                                  (t == 15) ? 32'h8000_0236 : 32'h8000_0230 + (t - 1);
                bus.i_ovf_clr   = (t == 15);
            end
            tick();
            idle_inputs();
            if (t == 5)  chk("fp_full_e5",  bus.o_full, 1);
            if (t == 13) chk("fp_full_e13", bus.o_full, 1);
            if (t == 14) begin
                chk("fp_full_e14", bus.o_full, 1);
                chk("fp_ovf_e14",  bus.o_ovf,  0);
                chk("fp_data_e14", lcd_data,   8'h31);
            end
            if (t == 15) chk("fp_ovf_set_over_clr", bus.o_ovf, 1);
            if (lcd_en && !prev_en) seen_d.push_back(lcd_data);
            prev_en = lcd_en;
        end
        chk("fp_pulses", seen_d.size(), 6);
        for (int k = 0; k < seen_d.size() && k < 6; k++) begin
            chk($sformatf("fp_data%0d", k), seen_d[k], 8'h30 + k);
        end
        bus.i_ovf_clr = 1'b1;
        tick();
        idle_inputs();
        chk("ovf_clr", bus.o_ovf, 0);

        // Pointer wrap: 10 words in pairs, FIFO never fills.
        do_reset();
        prev_en = 1'b0;
        bad_rw  = 1'b0;
        bad_ovf = 1'b0;
        seen_d.delete();
        for (int t = 0; t < 140; t++) begin
            if ((t % 26) < 2 && t < 130) begin
                bus.i_lcd_vld   = 1'b1;
                bus.i_lcd_wdata = 32'h8000_02A0 + 2 * (t / 26) + (t % 26);
            end
            tick();
            idle_inputs();
            if (lcd_rw !== 1'b0)    bad_rw  = 1'b1;
            if (bus.o_ovf !== 1'b0) bad_ovf = 1'b1;
            if (lcd_en && !prev_en) seen_d.push_back(lcd_data);
            prev_en = lcd_en;
        end
        chk("wrap_pulses", seen_d.size(), 10);
        for (int k = 0; k < seen_d.size() && k < 10; k++) begin
            chk($sformatf("wrap_data%0d", k), seen_d[k], 8'hA0 + k);
        end
        chk("wrap_rw_zero", bad_rw,  0);
        chk("wrap_no_ovf",  bad_ovf, 0);
        chk("wrap_idle",    bus.o_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
